mem_access_unit: RTL and testbench

- Initiator side of the data-memory interface. Sits between the MIPS MEM stage and the Memory block.
- Accepts load/store requests of byte, halfword or word size.
- Converts each request into word-aligned memory cycles on MemWrite/mem_addr/mem_write_data/mem_read_data. Sub-word stores use read-modify-write.
- Returns extracted, sign/zero-extended load data, or a misalignment error.

---
 rtl/mau_pkg.sv | 41 ++++
 rtl/mem_access_unit_if.sv | 34 +++
 rtl/mau_lane_align.sv | 77 +++++++
 rtl/mem_access_unit.sv | 99 +++++++++
 tb/tb_mem_access_unit.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/mau_pkg.sv
// Shared encodings for the data-memory access unit: request sizes,
// FSM states and the alignment rule applied at request accept.
package mau_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } mau_state_t;

    // Reserved size either errors out or behaves as a word access.
    function automatic logic [1:0] norm_size(
        input logic [1:0] sz,
        input logic       err_rsvd
    );
        return (sz == SZ_RSVD && !err_rsvd) ? SZ_WORD : sz;
    endfunction

    function automatic logic misaligned(
        input logic [1:0] sz,
        input logic [1:0] lo,
        input logic       err_rsvd
    );
        logic bad;
        bad = 1'b0;
        case (norm_size(sz, err_rsvd))
            SZ_HALF: bad = lo[0];
            SZ_WORD: bad = (lo != 2'b00);
            SZ_RSVD: bad = 1'b1;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake plus word-wide memory bus of the access unit.
// slave: the unit itself; master: requester and memory side.
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              MemWrite;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_write_data;
    logic [31:0]       mem_read_data;

    modport slave (
        input  req_valid, req_write, req_size, req_signed,
        input  req_addr, req_wdata, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output MemWrite, mem_addr, mem_write_data
    );

    modport master (
        output req_valid, req_write, req_size, req_signed,
        output req_addr, req_wdata, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  MemWrite, mem_addr, mem_write_data
    );
endinterface

// File: rtl/mau_lane_align.sv
// Byte/halfword lane extraction (loads) and insertion (stores).
// Little-endian lanes unless MAU_BIG_ENDIAN_EN is defined.
module mau_lane_align
    import mau_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lo,
    input  logic        sgn,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    function automatic int byte_sh(input logic [1:0] a);
`ifdef MAU_BIG_ENDIAN_EN
        return 24 - 8 * int'(a);
`else
        return 8 * int'(a);
`endif
    endfunction

    function automatic int half_sh(input logic a1);
`ifdef MAU_BIG_ENDIAN_EN
        return 16 - 16 * int'(a1);
`else
        return 16 * int'(a1);
`endif
    endfunction

    function automatic logic [31:0] extract(
        input logic [1:0]  sz,
        input logic [1:0]  a,
        input logic        s,
        input logic [31:0] w
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(w >> byte_sh(a));
        h = 16'(w >> half_sh(a[1]));
        case (sz)
            SZ_BYTE: r = {{24{s & b[7]}}, b};
            SZ_HALF: r = {{16{s & h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] insert(
        input logic [1:0]  sz,
        input logic [1:0]  a,
        input logic [31:0] w,
        input logic [31:0] d
    );
        int          sh;
        logic [31:0] r;
        case (sz)
            SZ_BYTE: begin
                sh = byte_sh(a);
                r  = (w & ~(32'h0000_00FF << sh))
                   | ({24'b0, d[7:0]} << sh);
            end
            SZ_HALF: begin
                sh = half_sh(a[1]);
                r  = (w & ~(32'h0000_FFFF << sh))
                   | ({16'b0, d[15:0]} << sh);
            end
            default: r = d;
        endcase
        return r;
    endfunction

    assign load_data = extract(size, lo, sgn, rdata);
    assign merged    = insert(size, lo, rdata, wdata);

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory initiator: one request at a time, word-aligned cycles,
// read-modify-write for sub-word stores. Option: MAU_BIG_ENDIAN_EN.
// Ports: clk, rst (async, active high), bus (slave modport).
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter bit ERR_ON_RESERVED = 1'b1
) (
    input logic               clk,
    input logic               rst,
    mem_access_unit_if.slave  bus
);

    mau_state_t  state;
    logic        wr_q;
    logic [1:0]  size_q;
    logic        sgn_q;
    logic [1:0]  lo_q;
    logic [31:0] wdata_q;
    logic [31:0] load_data;
    logic [31:0] merged;
    logic [1:0]  req_sz;
    logic        accept;

    assign req_sz = norm_size(bus.req_size, ERR_ON_RESERVED);
    assign accept = bus.req_valid && (state == ST_IDLE);

    // Decoded straight from state so reset removes them without a clock.
    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.resp_valid = (state == ST_RESP);
    assign bus.MemWrite   = (state == ST_WRITE);

    mau_lane_align u_align (
        .size      (size_q),
        .lo        (lo_q),
        .sgn       (sgn_q),
        .rdata     (bus.mem_read_data),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= ST_IDLE;
            wr_q               <= 1'b0;
            size_q             <= SZ_BYTE;
            sgn_q              <= 1'b0;
            lo_q               <= 2'b00;
            wdata_q            <= '0;
            bus.mem_addr       <= '0;
            bus.mem_write_data <= '0;
            bus.resp_rdata     <= '0;
            bus.resp_err       <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        wr_q           <= bus.req_write;
                        size_q         <= req_sz;
                        sgn_q          <= bus.req_signed;
                        lo_q           <= bus.req_addr[1:0];
                        wdata_q        <= bus.req_wdata;
                        bus.resp_rdata <= '0;
                        if (misaligned(bus.req_size, bus.req_addr[1:0],
                                       ERR_ON_RESERVED)) begin
                            // Error path leaves the memory bus untouched.
                            bus.resp_err <= 1'b1;
                            state        <= ST_RESP;
                        end else begin
                            bus.resp_err <= 1'b0;
                            bus.mem_addr <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                            if (bus.req_write && req_sz == SZ_WORD) begin
                                bus.mem_write_data <= bus.req_wdata;
                                state              <= ST_WRITE;
                            end else begin
                                state <= ST_READ;
                            end
                        end
                    end
                end
                ST_READ: begin
                    if (wr_q) begin
                        bus.mem_write_data <= merged;
                        state              <= ST_WRITE;
                    end else begin
                        bus.resp_rdata <= load_data;
                        state          <= ST_RESP;
                    end
                end
                ST_WRITE: state <= ST_RESP;
                ST_RESP:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a 16-word memory.
// Expected lane values follow MAU_BIG_ENDIAN_EN when it is defined.
module tb_mem_access_unit;

`ifdef MAU_BIG_ENDIAN_EN
    localparam logic [31:0] EXP_LB09 = 32'hFFFF_FFAD;
    localparam logic [31:0] EXP_LH0A = 32'h0000_BEEF;
    localparam logic [31:0] EXP_SB0B = 32'hDEAD_BE5A;
    localparam logic [31:0] EXP_LB08 = 32'h0000_00DE;
`else
    localparam logic [31:0] EXP_LB09 = 32'hFFFF_FFBE;
    localparam logic [31:0] EXP_LH0A = 32'h0000_DEAD;
    localparam logic [31:0] EXP_SB0B = 32'h5AAD_BEEF;
    localparam logic [31:0] EXP_LB08 = 32'h0000_00EF;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] mem [0:15];
    int          mw_cnt;
    logic [31:0] mw_addr;
    logic [31:0] mw_data;
    int          lat;
    logic        got;
    logic [31:0] r_rdata;
    logic        r_err;
    int          total;
    int          passed;
    int          fails;
    int          rv_seen;

    mem_access_unit_if #(.ADDR_W(32)) bus ();

    mem_access_unit #(
        .ADDR_W          (32),
        .ERR_ON_RESERVED (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_read_data = mem[bus.mem_addr[5:2]];

    // Memory commits on the falling edge of the write cycle.
    always @(negedge clk) begin
        if (bus.MemWrite) begin
            mw_cnt                 <= mw_cnt + 1;
            mw_addr                <= bus.mem_addr;
            mw_data                <= bus.mem_write_data;
            mem[bus.mem_addr[5:2]] <= bus.mem_write_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz,
                          input logic sg, input logic [31:0] a,
                          input logic [31:0] d);
        int n;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = d;
        n = 0;
        while (!bus.req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        mw_cnt = 0;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            if (bus.resp_valid) begin
                got     = 1'b1;
                r_rdata = bus.resp_rdata;
                r_err   = bus.resp_err;
            end
        end
        check("resp_timeout", 32'(got), 32'd1);
    endtask

    initial begin
        total = 0;
        passed = 0;
        fails = 0;
        mw_cnt = 0;
        mw_addr = '0;
        mw_data = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        rst = 1'b1;
        #1;
        check("rst_memwrite", 32'(bus.MemWrite), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_wdata", bus.mem_write_data, 32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_rdata", bus.resp_rdata, 32'd0);
        check("rst_err", 32'(bus.resp_err), 32'd0);
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_req(1'b1, 2'b10, 1'b0, 32'h08, 32'hDEAD_BEEF);
        check("sw_lat", lat, 2);
        check("sw_err", 32'(r_err), 32'd0);
        check("sw_mw_cnt", mw_cnt, 1);
        check("sw_mw_addr", mw_addr, 32'h08);
        check("sw_mw_data", mw_data, 32'hDEAD_BEEF);

        do_req(1'b0, 2'b00, 1'b1, 32'h09, 32'h0);
        check("lb_s_09", r_rdata, EXP_LB09);
        check("lb_lat", lat, 2);
        check("lb_mw_cnt", mw_cnt, 0);
        do_req(1'b0, 2'b01, 1'b0, 32'h0A, 32'h0);
        check("lh_u_0a", r_rdata, EXP_LH0A);
        do_req(1'b0, 2'b10, 1'b1, 32'h08, 32'h0);
        check("lw_08", r_rdata, 32'hDEAD_BEEF);
        do_req(1'b0, 2'b00, 1'b0, 32'h08, 32'h0);
        check("lb_u_08", r_rdata, EXP_LB08);

        do_req(1'b1, 2'b00, 1'b0, 32'h0B, 32'h1234_565A);
        check("sb_lat", lat, 3);
        check("sb_mw_cnt", mw_cnt, 1);
        check("sb_mw_data", mw_data, EXP_SB0B);
        check("sb_rdata", r_rdata, 32'd0);
        do_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
        check("lw_after_sb", r_rdata, EXP_SB0B);

        do_req(1'b0, 2'b01, 1'b1, 32'h0D, 32'h0);
        check("mis_lh_lat", lat, 1);
        check("mis_lh_err", 32'(r_err), 32'd1);
        check("mis_lh_rdata", r_rdata, 32'd0);
        do_req(1'b1, 2'b10, 1'b0, 32'h0E, 32'h1234_5678);
        check("mis_sw_lat", lat, 1);
        check("mis_sw_err", 32'(r_err), 32'd1);
        check("mis_sw_mw", mw_cnt, 0);
        do_req(1'b0, 2'b11, 1'b0, 32'h08, 32'h0);
        check("rsvd_err", 32'(r_err), 32'd1);
        check("rsvd_lat", lat, 1);
        do_req(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0);
        check("mem_unchanged", r_rdata, 32'd0);
        check("lw_ok_err", 32'(r_err), 32'd0);

        // Reset lands inside the WRITE cycle of a word store.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_size  = 2'b10;
        bus.req_addr  = 32'h0C;
        bus.req_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        check("wr_cycle_mw", 32'(bus.MemWrite), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rst_drop_mw", 32'(bus.MemWrite), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("rst_rel_ready", 32'(bus.req_ready), 32'd1);
        rv_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.resp_valid) rv_seen++;
        end
        check("rst_no_resp", rv_seen, 0);
        do_req(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0);
        check("rst_no_write", r_rdata, 32'd0);

        // req_valid held high across two word loads.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_size  = 2'b10;
        bus.req_addr  = 32'h08;
        check("b2b_ready0", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        check("b2b_ready1", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        check("b2b_resp1", 32'(bus.resp_valid), 32'd1);
        check("b2b_ready2", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        check("b2b_ready3", 32'(bus.req_ready), 32'd1);
        check("b2b_rv_pulse", 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("b2b_ready4", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        check("b2b_resp2", 32'(bus.resp_valid), 32'd1);
        check("b2b_rdata2", bus.resp_rdata, EXP_SB0B);
        @(negedge clk);
        check("b2b_idle", 32'(bus.req_ready), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
